// File: rtl/btn_conditioner_if.sv
// -----------------------------------------------------------------------------
// btn_conditioner_if
// Groups the raw button pin and the conditioned button events of btn_conditioner.
//
// Signals
//   btn_raw        raw button pin, active-low, asynchronous to the consumer clock
//   pressed        debounced level, active-high
//   press_pulse    1-cycle pulse on an accepted press
//   release_pulse  1-cycle pulse on an accepted release
//   long_pulse     1-cycle pulse when a hold reaches the long-press time
//   repeat_pulse   1-cycle pulse every repeat period while a long press is held
//
// Modports
//   master  drives the pin, observes the events (board / bench side)
//   slave   samples the pin, produces the events (btn_conditioner side)
// -----------------------------------------------------------------------------
interface btn_conditioner_if;
    logic btn_raw;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic repeat_pulse;

    modport master (
        output btn_raw,
        input  pressed,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  repeat_pulse
    );

    modport slave (
        input  btn_raw,
        output pressed,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output repeat_pulse
    );
endinterface

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Turns one raw active-low push-button into clean single-cycle events: 2-FF
// synchroniser, counter-based debouncer, press/release pulses, long-press
// detection and auto-repeat while held.
//
// Parameters
//   CLK_FREQ_HZ    clock frequency, all cycle counts are derived from it
//   DEBOUNCE_US    stable time needed to accept a level change
//   LONG_PRESS_MS  hold time before long_pulse
//   REPEAT_MS      repeat_pulse period once the long press is active
//
// Ports
//   clk        system clock
//   btn_reset  asynchronous reset, active-low
//   bus        btn_conditioner_if.slave: btn_raw in; pressed, press_pulse,
//              release_pulse, long_pulse, repeat_pulse out
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
    parameter int unsigned DEBOUNCE_US   = 1000,
    parameter int unsigned LONG_PRESS_MS = 500,
    parameter int unsigned REPEAT_MS     = 100
) (
    input logic              clk,
    input logic              btn_reset,
    btn_conditioner_if.slave bus
);

    localparam int unsigned CycPerUs = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned DebCyc   = CycPerUs * DEBOUNCE_US;
    localparam int unsigned LongCyc  = CycPerUs * LONG_PRESS_MS * 1000;
    localparam int unsigned RepCyc   = CycPerUs * REPEAT_MS * 1000;
    localparam int unsigned MaxLr    = (LongCyc > RepCyc) ? LongCyc : RepCyc;
    localparam int unsigned MaxCyc   = (DebCyc > MaxLr) ? DebCyc : MaxLr;
    localparam int unsigned CntW     = $clog2(MaxCyc) + 1;

    localparam logic [CntW-1:0] DebCnt   = CntW'(DebCyc);
    localparam logic [CntW-1:0] LongLast = CntW'(LongCyc - 1);
    localparam logic [CntW-1:0] RepLast  = CntW'(RepCyc - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};

    typedef enum logic [2:0] {
        StIdle,
        StPressWait,
        StPressed,
        StLong,
        StReleaseWait
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic            s_btn;
    logic            deb_done;
    logic            long_done;
    logic            rep_done;

    logic            pressed_lvl;
    logic            press_evt;
    logic            release_evt;
    logic            long_evt;
    logic            repeat_evt;

    // Synchronised pin, still active-low.
    assign s_btn     = sync_q[1];
    assign sync_d    = {sync_q[0], bus.btn_raw};
    assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
    assign deb_done  = (cnt_q == DebCnt);
    assign long_done = (cnt_q == LongLast);
    assign rep_done  = (cnt_q == RepLast);

    // Sync FFs reset to the released level so leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            sync_q  <= 2'b11;
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Release (s_btn high) is tested first so it wins over long/repeat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!s_btn) begin
                    state_d = StPressWait;
                    cnt_d   = CntOne;
                end
            end
            StPressWait: begin
                if (s_btn) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (deb_done) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end
            end
            StPressed: begin
                if (s_btn) begin
                    state_d = StReleaseWait;
                    cnt_d   = CntOne;
                end else if (long_done) begin
                    state_d = StLong;
                    cnt_d   = '0;
                end
            end
            StLong: begin
                if (s_btn) begin
                    state_d = StReleaseWait;
                    cnt_d   = CntOne;
                end else if (rep_done) begin
                    cnt_d = '0;
                end
            end
            StReleaseWait: begin
                // A low bounce restarts long-press timing from scratch.
                if (!s_btn) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (deb_done) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the registered state in the cycle the transition is taken,
    // giving DEB_CYC+2 cycles from pin edge to pulse.
    always_comb begin
        pressed_lvl = 1'b0;
        press_evt   = 1'b0;
        release_evt = 1'b0;
        long_evt    = 1'b0;
        repeat_evt  = 1'b0;
        unique case (state_q)
            StIdle: ;
            StPressWait: begin
                if (!s_btn && deb_done) begin
                    press_evt   = 1'b1;
                    pressed_lvl = 1'b1;
                end
            end
            StPressed: begin
                pressed_lvl = 1'b1;
                long_evt    = !s_btn && long_done;
            end
            StLong: begin
                pressed_lvl = 1'b1;
                repeat_evt  = !s_btn && rep_done;
            end
            StReleaseWait: begin
                if (s_btn && deb_done) begin
                    release_evt = 1'b1;
                end else begin
                    pressed_lvl = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.pressed       = pressed_lvl;
    assign bus.press_pulse   = press_evt;
    assign bus.release_pulse = release_evt;
    assign bus.long_pulse    = long_evt;
    assign bus.repeat_pulse  = repeat_evt;

endmodule
